// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Purpose  : Result/flag capture stage behind the 16-bit adder/subtractor:
//            2-entry FIFO, N/Z/C/V flags, sticky overflow and retire counter.
// Option   : define ALU_RESULT_SAT_EN to saturate overflowed results on push.
// Revision : 1.0
// ============================================================================
module alu_result_stage #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_cout,
   input  logic              in_overflow,
   input  logic              in_sub,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [3:0]        out_flags,
   output logic              sticky_v,
   input  logic              clr_sticky,
   output logic [CNT_W-1:0]  op_count
);

   logic [DATA_W-1:0] res_mem_q [2];
   logic [3:0]        flg_mem_q [2];

   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        occ_q, occ_d;
   logic              sticky_q, sticky_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              push;
   logic              pop;
   logic [DATA_W-1:0] store_res;
   logic [3:0]        store_flg;

   assign in_ready  = (occ_q != 2'd2);
   assign out_valid = (occ_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

`ifdef ALU_RESULT_SAT_EN
   // Sign of the wrapped result is inverted relative to the true result.
   always_comb begin
      store_res = in_result;
      if (in_overflow) begin
         store_res = in_result[DATA_W-1] ? {1'b0, {(DATA_W-1){1'b1}}}
                                         : {1'b1, {(DATA_W-1){1'b0}}};
      end
   end
`else
   assign store_res = in_result;
`endif

   // C is reported as a borrow for subtraction.
   assign store_flg = {store_res[DATA_W-1],
                       (store_res == '0),
                       (in_sub ? ~in_cout : in_cout),
                       in_overflow};

   always_ff @(posedge clk) begin
      if (push) begin
         res_mem_q[wr_ptr_q] <= store_res;
         flg_mem_q[wr_ptr_q] <= store_flg;
      end
   end

   always_comb begin
      occ_d    = occ_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
         cnt_d    = cnt_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
      if (pop && flg_mem_q[rd_ptr_q][0]) begin
         sticky_d = 1'b1;
      end else if (clr_sticky) begin
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q    <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         occ_q    <= occ_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_result = out_valid ? res_mem_q[rd_ptr_q] : '0;
   assign out_flags  = out_valid ? flg_mem_q[rd_ptr_q] : 4'd0;
   assign sticky_v   = sticky_q;
   assign op_count   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_stage
// Purpose  : Self-checking bench for alu_result_stage (vector table, directed
//            corner sequences, randomized traffic against a queue model).
// Revision : 1.0
// ============================================================================
module tb_alu_result_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic        in_cout;
   logic        in_overflow;
   logic        in_sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [3:0]  out_flags;
   logic        sticky_v;
   logic        clr_sticky;
   logic [15:0] op_count;

   int n_chk  = 0;
   int n_fail = 0;

`ifdef ALU_RESULT_SAT_EN
   localparam logic [15:0] OVF_RES = 16'h7FFF;
   localparam logic [3:0]  OVF_FLG = 4'b0001;
   localparam bit          SAT     = 1'b1;
`else
   localparam logic [15:0] OVF_RES = 16'h8000;
   localparam logic [3:0]  OVF_FLG = 4'b1001;
   localparam bit          SAT     = 1'b0;
`endif

   alu_result_stage #(.DATA_W(16), .CNT_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_result   (in_result),
      .in_cout     (in_cout),
      .in_overflow (in_overflow),
      .in_sub      (in_sub),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_flags   (out_flags),
      .sticky_v    (sticky_v),
      .clr_sticky  (clr_sticky),
      .op_count    (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: FIFO contents as a queue of {result, flags}.
   typedef struct packed {
      logic [15:0] res;
      logic [3:0]  flg;
   } ent_t;

   ent_t        mq[$];
   logic        m_sticky;
   logic [15:0] m_cnt;

   function automatic ent_t mk_entry(input logic [15:0] r, input logic co,
                                     input logic ov, input logic sb);
      ent_t        e;
      logic [15:0] v;
      v = r;
      if (SAT && ov) v = (r >= 16'h8000) ? 16'h7FFF : 16'h8000;
      e.res = v;
      e.flg = {(v >= 16'h8000), (v == 16'd0), (sb ? !co : co), ov};
      return e;
   endfunction

   task automatic model_step();
      bit pu, po;
      pu = in_valid && (mq.size() < 2);
      po = (mq.size() > 0) && out_ready;
      if (po && mq[0].flg[0]) m_sticky = 1'b1;
      else if (clr_sticky)    m_sticky = 1'b0;
      if (po) begin
         void'(mq.pop_front());
         m_cnt = m_cnt + 16'd1;
      end
      if (pu) mq.push_back(mk_entry(in_result, in_cout, in_overflow, in_sub));
   endtask

   task automatic model_reset();
      mq.delete();
      m_sticky = 1'b0;
      m_cnt    = 16'd0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      ent_t hd;
      hd = (mq.size() > 0) ? mq[0] : '0;
      chk({tag, " out_valid"},  {31'd0, out_valid}, {31'd0, mq.size() > 0});
      chk({tag, " in_ready"},   {31'd0, in_ready},  {31'd0, mq.size() < 2});
      chk({tag, " out_result"}, {16'd0, out_result}, {16'd0, hd.res});
      chk({tag, " out_flags"},  {28'd0, out_flags},  {28'd0, hd.flg});
      chk({tag, " sticky_v"},   {31'd0, sticky_v},  {31'd0, m_sticky});
      chk({tag, " op_count"},   {16'd0, op_count},  {16'd0, m_cnt});
   endtask

   // One clock: inputs already set; model follows the same edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input logic iv, input logic [15:0] r, input logic co,
                        input logic ov, input logic sb, input logic ordy,
                        input logic clr);
      in_valid = iv; in_result = r; in_cout = co;
      in_overflow = ov; in_sub = sb; out_ready = ordy; clr_sticky = clr;
   endtask

   typedef struct packed {
      logic        iv;
      logic [15:0] res;
      logic        co, ov, sb, ordy, clr;
      logic        e_ov, e_ir;
      logic [15:0] e_res;
      logic [3:0]  e_flg;
      logic        e_st;
      logic [15:0] e_cnt;
   } vec_t;

   function automatic vec_t mkv(input logic iv, input logic [15:0] r, input logic co,
                                input logic ov, input logic sb, input logic ordy,
                                input logic clr, input logic e_ov, input logic e_ir,
                                input logic [15:0] e_res, input logic [3:0] e_flg,
                                input logic e_st, input logic [15:0] e_cnt);
      vec_t v;
      v.iv = iv; v.res = r; v.co = co; v.ov = ov; v.sb = sb; v.ordy = ordy;
      v.clr = clr; v.e_ov = e_ov; v.e_ir = e_ir; v.e_res = e_res;
      v.e_flg = e_flg; v.e_st = e_st; v.e_cnt = e_cnt;
      return v;
   endfunction

   vec_t vt [15];

   initial begin
      //           iv    res       co  ov  sb  rdy clr   e_ov e_ir e_res     e_flg    st  cnt
      vt[0]  = mkv(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 4'b0100, 1'b0, 16'd0);
      vt[1]  = mkv(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0000, 1'b0, 16'd1);
      vt[2]  = mkv(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 4'b0000, 1'b0, 16'd1);
      vt[3]  = mkv(1'b1, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 4'b0000, 1'b0, 16'd1);
      vt[4]  = mkv(1'b1, 16'h9ABC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 4'b0000, 1'b0, 16'd1);
      vt[5]  = mkv(1'b1, 16'h9ABC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5678, 4'b0000, 1'b0, 16'd2);
      vt[6]  = mkv(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0000, 1'b0, 16'd3);
      vt[7]  = mkv(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 4'b0000, 1'b0, 16'd3);
      vt[8]  = mkv(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 4'b0000, 1'b0, 16'd4);
      vt[9]  = mkv(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 4'b1010, 1'b0, 16'd5);
      vt[10] = mkv(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, OVF_RES,  OVF_FLG, 1'b0, 16'd6);
      vt[11] = mkv(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 4'b0000, 1'b1, 16'd7);
      vt[12] = mkv(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'b0000, 1'b0, 16'd7);
      vt[13] = mkv(1'b1, 16'h8001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8001, 4'b1010, 1'b0, 16'd7);
      vt[14] = mkv(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0000, 1'b0, 16'd8);

      rst_n = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("reset out_valid",  {31'd0, out_valid}, 32'd0);
      chk("reset in_ready",   {31'd0, in_ready},  32'd1);
      chk("reset out_result", {16'd0, out_result}, 32'd0);
      chk("reset out_flags",  {28'd0, out_flags},  32'd0);
      chk("reset sticky_v",   {31'd0, sticky_v},  32'd0);
      chk("reset op_count",   {16'd0, op_count},  32'd0);

      for (int i = 0; i < 15; i++) begin
         drive(vt[i].iv, vt[i].res, vt[i].co, vt[i].ov, vt[i].sb, vt[i].ordy, vt[i].clr);
         tick();
         chk($sformatf("vec%0d out_valid", i),  {31'd0, out_valid}, {31'd0, vt[i].e_ov});
         chk($sformatf("vec%0d in_ready", i),   {31'd0, in_ready},  {31'd0, vt[i].e_ir});
         chk($sformatf("vec%0d out_result", i), {16'd0, out_result}, {16'd0, vt[i].e_res});
         chk($sformatf("vec%0d out_flags", i),  {28'd0, out_flags},  {28'd0, vt[i].e_flg});
         chk($sformatf("vec%0d sticky_v", i),   {31'd0, sticky_v},  {31'd0, vt[i].e_st});
         chk($sformatf("vec%0d op_count", i),   {16'd0, op_count},  {16'd0, vt[i].e_cnt});
      end

      // Mid-operation reset with two entries buffered and sticky set.
      drive(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
      drive(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      chk("prerst in_ready", {31'd0, in_ready}, 32'd0);
      chk("prerst sticky_v", {31'd0, sticky_v}, 32'd1);
      chk("prerst op_count", {16'd0, op_count}, 32'd9);
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst out_valid",  {31'd0, out_valid}, 32'd0);
      chk("midrst in_ready",   {31'd0, in_ready},  32'd1);
      chk("midrst sticky_v",   {31'd0, sticky_v},  32'd0);
      chk("midrst op_count",   {16'd0, op_count},  32'd0);
      chk("midrst out_result", {16'd0, out_result}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk_model("postrst");

      // Randomized traffic against the queue model.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(3, 0) != 0),
               ($urandom_range(7, 0) == 0) ? 16'h0000 : 16'($urandom),
               1'($urandom), ($urandom_range(5, 0) == 0), 1'($urandom),
               ($urandom_range(2, 0) != 0), ($urandom_range(7, 0) == 0));
         tick();
         chk_model("rand");
      end

      // Counter wrap: one entry primed, then push+pop every cycle.
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      for (int i = 0; i < 65535; i++) begin
         drive(1'b1, 16'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         tick();
      end
      chk("wrap op_count ffff", {16'd0, op_count}, 32'h0000FFFF);
      chk_model("wrap pre");
      drive(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
      chk("wrap op_count 0",  {16'd0, op_count}, 32'd0);
      chk("wrap out_valid",   {31'd0, out_valid}, 32'd1);
      chk("wrap in_ready",    {31'd0, in_ready},  32'd1);
      chk("wrap out_result",  {16'd0, out_result}, 32'h000000AA);
      chk_model("wrap post");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Output stage directly downstream of the 16-bit adder/subtractor.
- Captures each sum/difference with its carry-out and overflow and derives N/Z/C/V flags.
- Buffers results in a 2-entry FIFO with valid/ready handshakes on both sides.
- Keeps a sticky overflow flag and a retired-operation counter for the CALU status path.

Parameters:
- DATA_W, 16, result width; all width rules below are stated for DATA_W=16.
- CNT_W, 16, width of the retired-operation counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream result is present.
- in_ready  output  1  stage can accept; equals (occupancy < 2).
- in_result  input  DATA_W  adder/subtractor Result.
- in_cout  input  1  adder/subtractor Cout.
- in_overflow  input  1  adder/subtractor Overflow.
- in_sub  input  1  Sub value used for this operation.
- out_valid  output  1  head entry available; equals (occupancy > 0).
- out_ready  input  1  downstream accepts the head entry.
- out_result  output  DATA_W  head entry result.
- out_flags  output  4  head entry flags {N,Z,C,V}, bit3 = N.
- sticky_v  output  1  set when any retired entry had V=1.
- clr_sticky  input  1  synchronous clear of sticky_v.
- op_count  output  CNT_W  number of retired entries.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Occupancy 0, so out_valid=0 and in_ready=1.
  - Read and write pointers 0.
  - sticky_v=0, op_count=0.
  - out_result=0, out_flags=0; storage contents are don't-care.
  - Reset asserted mid-operation discards all buffered entries immediately.
- Push: in_valid && in_ready on a rising edge writes one entry at the write pointer.
- Pop: out_valid && out_ready on a rising edge advances the read pointer.
- Latency: an entry pushed into an empty stage appears on out_* in the following cycle. There is no same-cycle bypass.
- Outputs are driven from storage only. out_result and out_flags show the head entry whenever out_valid=1 and are 0 when the stage is empty.
- Flag derivation at push time:
  - N = stored result[15].
  - Z = (stored result == 0).
  - C = in_sub ? ~in_cout : in_cout (C is a borrow for subtraction).
  - V = in_overflow.
- Occupancy cases:
  - Empty (0): pop is impossible; a push makes occupancy 1.
  - Occupancy 1: push and pop in the same cycle keeps occupancy 1. The new entry becomes the head next cycle.
  - Full (2): in_ready=0, and in_valid is ignored. A pop makes occupancy 1, and in_ready returns to 1 in the next cycle.
- Pointers are 1 bit each and wrap 1 -> 0.
- Upstream holds in_* stable while in_valid && !in_ready. The stage does not check this.
- Downstream may hold out_ready low indefinitely. Head data stays stable while out_valid && !out_ready.
- sticky_v:
  - Set on a pop whose entry has V=1.
  - Cleared by clr_sticky=1.
  - If set and clear occur in the same cycle, set wins and sticky_v=1.
- op_count:
  - Increments by 1 on each pop.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - Not affected by clr_sticky.

Optional Feature:
- Macro: ALU_RESULT_SAT_EN.
- Defined: on a push with in_overflow=1, the stored result is saturated.
  - in_result[15]=1 (positive overflow) stores 16'h7FFF.
  - in_result[15]=0 (negative overflow) stores 16'h8000.
  - N and Z are computed from the saturated value. V stays 1, C is unchanged.
  - Entries with in_overflow=0 are stored unmodified.
- Undefined: in_result is stored unmodified. No saturation logic is present.

Test Plan:
- Reset then single push: rst_n low, release, push result=16'h0000, cout=1, sub=1, ovf=0.
  - Next cycle: out_valid=1, out_result=0, out_flags=4'b0100 (Z=1, C=0 borrow-free).
  - Pop: op_count=1.
- Fill/backpressure: out_ready=0, push 16'h1234 then 16'h5678.
  - in_ready=0 after the second push; a third in_valid is ignored.
  - Raise out_ready: outputs 16'h1234 then 16'h5678 in order; in_ready=1 one cycle after the first pop.
- Simultaneous push/pop at occupancy 1: head 16'h0001 popped while 16'h0002 pushed.
  - Next cycle: out_result=16'h0002, occupancy 1, op_count incremented.
- Overflow, sticky and saturation: push result=16'h8000, ovf=1, sub=0, cout=0.
  - Without macro: out_flags=4'b1001.
  - With ALU_RESULT_SAT_EN: out_result=16'h7FFF, out_flags=4'b0001.
  - Pop with clr_sticky=1 in the same cycle: sticky_v=1. Clear next cycle: sticky_v=0.
- Counter wrap: retire 65536 entries. op_count goes 16'hFFFF -> 16'h0000, and out_valid/in_ready are unaffected.
- Reset mid-operation: two entries buffered, assert rst_n low between clock edges.
  - Immediately: out_valid=0, in_ready=1, sticky_v=0, op_count=0.
